bios_loader_chipset: RTL

- Parametrised boot chipset between ROM, main memory and CPU.
- After reset it streams LOAD_LEN words from the block ROM into memory starting at LOAD_BASE, holding the CPU off the bus while it does so.
- It then multiplexes the memory bus to the CPU.
- A reload request repeats the copy without a full reset.

---
 rtl/bios_loader_chipset.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bios_loader_chipset.sv
// Boot chipset: copies LOAD_LEN ROM words into memory from LOAD_BASE, then hands the memory bus to the CPU.
// Optional running checksum of the loaded image (load_sum/load_ok) when BIOS_LOADER_CHECKSUM_EN is defined.
module bios_loader_chipset #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int ROM_DEPTH = 256,
    parameter int LOAD_LEN  = 256,
    parameter int LOAD_BASE = 0,
    parameter     ROM_FILE  = "test.mem",
    // Image named by ROM_FILE, pre-packed with word 0 in the least significant DATA_W bits.
    parameter logic [ROM_DEPTH*DATA_W-1:0] ROM_INIT = '0
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              reload_req,
    input  logic [DATA_W-1:0] mem_read_bus,
    output logic [1:0]        mem_ctrl_bus,
    output logic [ADDR_W-1:0] mem_addr_bus,
    output logic [DATA_W-1:0] mem_write_bus,
    input  logic [1:0]        cpu_ctrl_bus,
    input  logic [ADDR_W-1:0] cpu_addr_bus,
    input  logic [DATA_W-1:0] cpu_write_bus,
    output logic [DATA_W-1:0] cpu_read_bus,
    output logic              cpu_hold,
    output logic [1:0]        dbg_state,
    output logic              load_done
`ifdef BIOS_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] load_sum,
    output logic              load_ok
`endif
);

    // Memory command encoding shared by the CPU and memory buses.
    localparam logic [1:0] MEM_NOP   = 2'd0;
    localparam logic [1:0] MEM_READ  = 2'd1;
    localparam logic [1:0] MEM_WRITE = 2'd2;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam int ROM_AW       = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int ROM_NAME_LEN = $bits(ROM_FILE);
    localparam logic [ROM_AW-1:0] LAST_INDEX = ROM_AW'(LOAD_LEN - 1);

    if (LOAD_LEN < 1 || LOAD_LEN > ROM_DEPTH || ROM_NAME_LEN == 0) begin : g_bad_cfg
        $error("bios_loader_chipset: LOAD_LEN must lie in 1..ROM_DEPTH and ROM_FILE must be named");
    end

    logic [DATA_W-1:0] rom [ROM_DEPTH];
    for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
        assign rom[g] = ROM_INIT[g*DATA_W +: DATA_W];
    end

    logic [1:0]        state;
    logic [ROM_AW-1:0] index;
    logic [1:0]        wr_ctrl;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] load_addr;

    // Wraps silently past the top of the address space.
    assign load_addr = ADDR_W'(LOAD_BASE + 32'(index));

    // The write stage is the ROM's read register: the word addressed by index lands here one edge later.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state   <= ST_LOAD;
            index   <= '0;
            wr_ctrl <= MEM_NOP;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    wr_ctrl <= MEM_WRITE;
                    wr_addr <= load_addr;
                    wr_data <= rom[index];
                    if (index == LAST_INDEX) begin
                        state <= ST_DRAIN;
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    wr_ctrl <= MEM_NOP;
                    wr_addr <= '0;
                    wr_data <= '0;
                    state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (reload_req) begin
                        state <= ST_LOAD;
                        index <= '0;
                    end
                end
                default: begin
                    state <= ST_LOAD;
                    index <= '0;
                end
            endcase
        end
    end

    always_comb begin
        mem_ctrl_bus  = wr_ctrl;
        mem_addr_bus  = wr_addr;
        mem_write_bus = wr_data;
        cpu_read_bus  = '0;
        if (state == ST_RUN) begin
            mem_ctrl_bus  = cpu_ctrl_bus;
            mem_addr_bus  = cpu_addr_bus;
            mem_write_bus = cpu_write_bus;
            cpu_read_bus  = mem_read_bus;
        end
    end

    assign cpu_hold  = (state != ST_RUN);
    assign load_done = (state == ST_RUN);
    assign dbg_state = state;

`ifdef BIOS_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    // Accumulates at the same edge that captures each word into the write stage.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sum_q <= '0;
        end else if (state == ST_LOAD) begin
            sum_q <= sum_q + rom[index];
        end else if (state == ST_RUN && reload_req) begin
            sum_q <= '0;
        end
    end

    assign load_sum = sum_q;
    assign load_ok  = (state == ST_RUN) && (sum_q == '0);
`endif

endmodule
